// File: rtl/lsu_dmem_master.sv
// Load/store unit driving a word-wide data memory: RMW for SB/SH, lane extract/extend for loads.
// Optional build macro LSU_BYTE_STROBE_EN adds memByteEn and turns SB/SH into single writes.
module lsu_dmem_master #(
   parameter int unsigned MEM_SIZE_KB = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [2:0]  reqFunct3,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWData,
   output logic        respValid,
   output logic [31:0] respRData,
   output logic        respErr,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] memAddr,
   output logic [31:0] memWriteData,
   output logic [2:0]  memFunct3,
`ifdef LSU_BYTE_STROBE_EN
   output logic [3:0]  memByteEn,
`endif
   input  logic [31:0] memReadData
);

   localparam logic [31:0] MEM_BYTES = 32'(MEM_SIZE_KB * 1024);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef LSU_BYTE_STROBE_EN
   logic [3:0]  be_q, be_d;
`endif

   logic        req_byte, req_half, req_word, legal_f3, misalign, req_err;
   logic [4:0]  shamt;
   logic [31:0] shifted, lane_mask, lane_data, merged, load_val;

   assign req_byte = (reqFunct3[1:0] == 2'b00);
   assign req_half = (reqFunct3[1:0] == 2'b01);
   assign req_word = (reqFunct3 == 3'b010);
   assign legal_f3 = reqWrite ? (reqFunct3[2] == 1'b0 && reqFunct3[1:0] != 2'b11)
                              : (reqFunct3 != 3'b011 && reqFunct3 != 3'b110 && reqFunct3 != 3'b111);
   assign misalign = (req_half && reqAddr[0]) || (req_word && reqAddr[1:0] != 2'b00);
   assign req_err  = !legal_f3 || misalign || (reqAddr >= MEM_BYTES);

   // Half lanes are always 2-byte aligned here, so lane*8 covers both byte and half selects.
   assign shamt     = {lane_q, 3'b000};
   assign shifted   = memReadData >> shamt;
   assign lane_mask = ((funct3_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
   assign lane_data = ({16'h0000, wdata_q} << shamt) & lane_mask;
   assign merged    = (memReadData & ~lane_mask) | lane_data;

   always_comb begin
      load_val = memReadData;
      case (funct3_q)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_val = {24'h000000, shifted[7:0]};
         3'b101:  load_val = {16'h0000, shifted[15:0]};
         default: load_val = memReadData;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      funct3_d    = funct3_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef LSU_BYTE_STROBE_EN
      be_d        = be_q;
`endif
      case (state_q)
         IDLE: begin
            if (reqValid) begin
               write_d  = reqWrite;
               funct3_d = reqFunct3;
               lane_d   = reqAddr[1:0];
               wdata_d  = reqWData[15:0];
               err_d    = req_err;
               rdata_d  = 32'h0;
               if (req_err) begin
                  state_d = RESP;
               end else begin
                  mem_addr_d = {reqAddr[31:2], 2'b00};
                  if (!reqWrite) begin
                     state_d = READ;
                  end else if (req_word) begin
                     state_d     = WRITE;
                     mem_wdata_d = reqWData;
`ifdef LSU_BYTE_STROBE_EN
                     be_d        = 4'b1111;
`endif
                  end else begin
`ifdef LSU_BYTE_STROBE_EN
                     state_d     = WRITE;
                     mem_wdata_d = req_byte ? {4{reqWData[7:0]}} : {2{reqWData[15:0]}};
                     be_d        = (req_byte ? 4'b0001 : 4'b0011) << reqAddr[1:0];
`else
                     state_d     = READ;
`endif
                  end
               end
            end
         end
         READ: begin
            if (write_q) begin
               mem_wdata_d = merged;
               state_d     = WRITE;
            end else begin
               rdata_d = load_val;
               state_d = RESP;
            end
         end
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         funct3_q    <= 3'b000;
         lane_q      <= 2'b00;
         wdata_q     <= 16'h0;
         err_q       <= 1'b0;
         rdata_q     <= 32'h0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
`ifdef LSU_BYTE_STROBE_EN
         be_q        <= 4'b0000;
`endif
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         funct3_q    <= funct3_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef LSU_BYTE_STROBE_EN
         be_q        <= be_d;
`endif
      end
   end

   // Strobes are gated with rst so an aborted RMW never commits in the reset cycle.
   assign reqReady     = rst || (state_q == IDLE);
   assign respValid    = !rst && (state_q == RESP);
   assign respRData    = respValid ? rdata_q : 32'h0;
   assign respErr      = respValid && err_q;
   assign memRead      = !rst && (state_q == READ);
   assign memWrite     = !rst && (state_q == WRITE);
   assign memAddr      = mem_addr_q;
   assign memWriteData = mem_wdata_q;
   assign memFunct3    = 3'b010;
`ifdef LSU_BYTE_STROBE_EN
   assign memByteEn    = memWrite ? be_q : 4'b0000;
`endif

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Self-checking bench for lsu_dmem_master: directed steps plus random traffic against a byte-level memory model.
module tb_lsu_dmem_master;
   logic        clk = 1'b0;
   logic        rst;
   logic        reqValid, reqReady, reqWrite;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddr, reqWData;
   logic        respValid, respErr, memRead, memWrite;
   logic [31:0] respRData, memAddr, memWriteData, memReadData;
   logic [2:0]  memFunct3;
`ifdef LSU_BYTE_STROBE_EN
   logic [3:0]  memByteEn;
`endif

   always #5 clk = ~clk;

   lsu_dmem_master #(.MEM_SIZE_KB(1)) dut (
      .clk(clk), .rst(rst),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWData(reqWData),
      .respValid(respValid), .respRData(respRData), .respErr(respErr),
      .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
      .memWriteData(memWriteData), .memFunct3(memFunct3),
`ifdef LSU_BYTE_STROBE_EN
      .memByteEn(memByteEn),
`endif
      .memReadData(memReadData)
   );

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];

   assign memReadData = mem[memAddr[9:2]];

   always @(posedge clk) begin
      if (memWrite) begin
`ifdef LSU_BYTE_STROBE_EN
         for (int b = 0; b < 4; b++)
            if (memByteEn[b]) mem[memAddr[9:2]][b*8 +: 8] <= memWriteData[b*8 +: 8];
`else
         mem[memAddr[9:2]] <= memWriteData;
`endif
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: byte-addressed view of memory, RV32I load/store semantics.
   task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd,
                        output int lat);
      int size;
      logic legal;
      logic [31:0] word, val;
      int off;
      legal = w ? (f3 == 0 || f3 == 1 || f3 == 2)
                : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      err  = !legal || (a % size != 0) || (a >= 1024);
      rd   = 32'h0;
      off  = int'(a % 4);
      if (err) begin
         lat = 1;
      end else if (!w) begin
         word = ref_mem[a / 4];
         val  = word >> (8 * off);
         lat  = 2;
         if (size == 1) begin
            rd = val & 32'hFF;
            if (!f3[2] && rd >= 128) rd = rd | 32'hFFFF_FF00;
         end else if (size == 2) begin
            rd = val & 32'hFFFF;
            if (!f3[2] && rd >= 32768) rd = rd | 32'hFFFF_0000;
         end else begin
            rd = word;
         end
      end else begin
         for (int i = 0; i < size; i++)
            ref_mem[a / 4][(off + i) * 8 +: 8] = wd[i * 8 +: 8];
`ifdef LSU_BYTE_STROBE_EN
         lat = 2;
`else
         lat = (size == 4) ? 2 : 3;
`endif
      end
   endtask

   logic [31:0] last_wdata;
   logic [3:0]  last_be;
   logic        saw_rd, saw_wr;

   task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd_got);
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat, n;
      model(w, f3, a, wd, e_err, e_rd, e_lat);
      @(negedge clk);
      chk({tag, ".ready"}, {31'h0, reqReady}, 32'h1);
      reqValid = 1'b1; reqWrite = w; reqFunct3 = f3; reqAddr = a; reqWData = wd;
      @(posedge clk);
      #1 reqValid = 1'b0;
      n = 0; saw_rd = 1'b0; saw_wr = 1'b0; rd_got = 32'hDEAD_BEEF;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (memRead) saw_rd = 1'b1;
         if (memWrite) begin
            saw_wr = 1'b1;
            last_wdata = memWriteData;
`ifdef LSU_BYTE_STROBE_EN
            last_be = memByteEn;
`endif
         end
         if (respValid) begin
            n = i;
            rd_got = respRData;
            chk({tag, ".err"}, {31'h0, respErr}, {31'h0, e_err});
            break;
         end
         if (respRData !== 32'h0 || respErr !== 1'b0)
            chk({tag, ".idle_resp"}, {respRData[30:0], respErr}, 32'h0);
      end
      chk({tag, ".latency"}, n, e_lat);
      chk({tag, ".rdata"}, rd_got, e_rd);
      if (e_err) chk({tag, ".noaccess"}, {30'h0, saw_rd, saw_wr}, 32'h0);
   endtask

   logic [31:0] r;
   logic [2:0]  legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   int          bad;

   initial begin
      rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = 3'b0;
      reqAddr = 32'h0; reqWData = 32'h0; last_wdata = 32'h0; last_be = 4'h0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("reset.outs", {24'h0, reqReady, respValid, respErr, memRead, memWrite, memFunct3}, {24'h0, 5'b10000, 3'b010});
         chk("reset.rdata", respRData, 32'h0);
         chk("reset.addr", memAddr | memWriteData, 32'h0);
      end
      rst = 1'b0;

      do_req("sw10", 1, 3'b010, 32'h10, 32'h8000_00FF, r);
      do_req("lb10", 0, 3'b000, 32'h10, 32'h0, r);  chk("lb10.val", r, 32'hFFFF_FFFF);
      do_req("lb13", 0, 3'b000, 32'h13, 32'h0, r);  chk("lb13.val", r, 32'hFFFF_FF80);
      do_req("lbu13", 0, 3'b100, 32'h13, 32'h0, r); chk("lbu13.val", r, 32'h0000_0080);

      do_req("sw20", 1, 3'b010, 32'h20, 32'h1122_3344, r);
      do_req("sb21", 1, 3'b000, 32'h21, 32'h0000_00AB, r);
`ifdef LSU_BYTE_STROBE_EN
      chk("sb21.path", {30'h0, saw_rd, saw_wr}, 32'h1);
      chk("sb21.wdata", last_wdata, 32'hABAB_ABAB);
      chk("sb21.be", {28'h0, last_be}, 32'h2);
`else
      chk("sb21.path", {30'h0, saw_rd, saw_wr}, 32'h3);
      chk("sb21.wdata", last_wdata, 32'h1122_AB44);
`endif
      do_req("lw20", 0, 3'b010, 32'h20, 32'h0, r); chk("lw20.val", r, 32'h1122_AB44);

      do_req("lh21", 0, 3'b001, 32'h21, 32'h0, r);
      do_req("sw22", 1, 3'b010, 32'h22, 32'h5555_5555, r);
      do_req("lw400", 0, 3'b010, 32'h400, 32'h0, r);
      do_req("ld011", 0, 3'b011, 32'h24, 32'h0, r);
      do_req("st100", 1, 3'b100, 32'h24, 32'h0, r);

      do_req("sw30", 1, 3'b010, 32'h30, 32'h8001_0000, r);
      do_req("lh32", 0, 3'b001, 32'h32, 32'h0, r);  chk("lh32.val", r, 32'hFFFF_8001);
      do_req("lhu32", 0, 3'b101, 32'h32, 32'h0, r); chk("lhu32.val", r, 32'h0000_8001);

      // Abort an SB by asserting rst during its READ cycle.
      do_req("sw40", 1, 3'b010, 32'h40, 32'hCAFE_F00D, r);
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'b000; reqAddr = 32'h41; reqWData = 32'h77;
      @(posedge clk);
      #1 reqValid = 1'b0;
      @(negedge clk);
`ifndef LSU_BYTE_STROBE_EN
      chk("abort.read_cycle", {31'h0, memRead}, 32'h1);
`endif
      rst = 1'b1;
      #1 chk("abort.gated", {30'h0, memRead, memWrite}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("abort.idle", {29'h0, reqReady, respValid, memWrite}, 32'h4);
      saw_wr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (respValid || memWrite) saw_wr = 1'b1;
      end
      chk("abort.quiet", {31'h0, saw_wr}, 32'h0);
      do_req("lw40", 0, 3'b010, 32'h40, 32'h0, r); chk("lw40.val", r, 32'hCAFE_F00D);

      for (int k = 0; k < 60; k++) begin
         logic        w;
         logic [2:0]  f3;
         logic [31:0] a;
         w = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
         else if (w)                     f3 = 3'($urandom_range(0, 2));
         else                            f3 = legal_ld[$urandom_range(0, 4)];
         if ($urandom_range(0, 9) == 0) a = 32'h400 + $urandom_range(0, 255);
         else                           a = $urandom_range(0, 1023);
         if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            else if (f3[1:0] != 2'b00) a[1:0] = 2'b00;
         end
         do_req($sformatf("rnd%0d", k), w, f3, a, $urandom, r);
      end

      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("final.mem", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store unit on the CPU side of the data-memory port; it is the initiator that drives memRead/memWrite/addr/writeData/funct3 into the data memory.
- Accepts one load/store request at a time from the execute stage.
- Issues word-only memory accesses; byte and halfword lanes are extracted and sign/zero-extended locally.
- Performs read-modify-write for SB/SH, detects misaligned and out-of-range accesses, and returns one response per request.

Parameters:
- MEM_SIZE_KB, 1, data memory size in KB; byte addresses >= MEM_SIZE_KB*1024 are out of range.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous active-high reset
- reqValid  input  1  request present
- reqReady  output  1  LSU can accept a request; high only in IDLE
- reqWrite  input  1  1 = store, 0 = load
- reqFunct3  input  3  RV32I funct3: loads 000/001/010/100/101, stores 000/001/010
- reqAddr  input  32  byte address
- reqWData  input  32  store data; SB uses [7:0], SH uses [15:0]
- respValid  output  1  one-cycle response pulse
- respRData  output  32  load result, extended; 0 for stores and errors
- respErr  output  1  misaligned, out-of-range or illegal funct3; valid with respValid
- memRead  output  1  memory read enable
- memWrite  output  1  memory write enable; committed by memory at posedge
- memAddr  output  32  word-aligned byte address, [1:0]=00
- memWriteData  output  32  full word to write
- memFunct3  output  3  constant 3'b010, word access
- memReadData  input  32  combinational read data, valid in the same cycle memRead=1

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset: state=IDLE. reqReady=1, respValid=0, respRData=0, respErr=0, memRead=0, memWrite=0, memAddr=0, memWriteData=0.
- memRead/memWrite are decoded from state and gated with !rst, so no write commits in a reset cycle.
- Accept: in IDLE with reqValid=1, latch reqWrite, reqFunct3, reqAddr, reqWData.
- Error check at accept; error requests go to RESP with respErr=1 and make no memory access:
  - halfword ops with addr[0]=1
  - word ops with addr[1:0]!=0
  - reqAddr >= MEM_SIZE_KB*1024
  - funct3 not legal for the direction
- Legal load: IDLE->READ->RESP.
  - READ: memRead=1, memAddr={addr[31:2],2'b00}; capture memReadData.
  - Lane select by addr[1:0]: byte lane = addr[1:0]*8, half lane = addr[1]*16.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - Latency from accept to respValid = 2 cycles.
- SW: IDLE->WRITE->RESP. WRITE drives memWrite=1, memWriteData=reqWData. Latency 2.
- SB/SH: IDLE->READ->WRITE->RESP.
  - READ captures the old word.
  - WRITE writes it with only the addressed byte/half replaced by reqWData[7:0] or [15:0]; other lanes unchanged.
  - Latency 3.
- RESP: respValid=1 for exactly one cycle, then IDLE. No response backpressure.
- Throughput: the next request can be accepted in the cycle after RESP.
- reqValid outside IDLE is ignored; the requester must hold reqValid until reqReady.
- respRData=0 and respErr=0 whenever respValid=0.
- Reset mid-operation: abort at the next edge and return to IDLE. No response is issued for the aborted request. A pending RMW write is dropped and memory is unchanged.
- memAddr/memWriteData hold their last values when memRead=memWrite=0; contents are don't-care but must be deterministic.

Optional Feature:
- LSU_BYTE_STROBE_EN
- Defined:
  - Adds output memByteEn[3:0].
  - SB/SH skip READ: IDLE->WRITE->RESP, latency 2.
  - memByteEn = 0001<<addr[1:0] for SB, 0011<<addr[1:0] for SH, 1111 for SW.
  - memWriteData replicates store data across lanes: SB {4{b}}, SH {2{h}}.
  - memByteEn=0000 when memWrite=0.
- Undefined: no memByteEn port; read-modify-write as above.

Test Plan:
- Reset hold 3 cycles -> all outputs at reset values, reqReady=1, no memRead/memWrite.
- SW 0x8000_00FF at 0x10, then LB at 0x10 and 0x13, LBU at 0x13 -> respRData 0xFFFF_FFFF, 0xFFFF_FF80, 0x0000_0080; each respValid exactly 2 cycles after accept.
- Word 0x1122_3344 at 0x20; SB 0xAB at 0x21 -> READ then WRITE of 0x1122_AB44; LW 0x20 returns 0x1122_AB44. With LSU_BYTE_STROBE_EN: single WRITE, memByteEn=0010, memWriteData=0xABAB_ABAB.
- LH at 0x21, SW at 0x22, LW at 0x400 with MEM_SIZE_KB=1, load with funct3 011 -> respErr=1, respRData=0, 1-cycle latency, memRead=memWrite=0 throughout.
- LH 0x8001 at 0x32 on word 0x8001_0000 -> 0xFFFF_8001; LHU -> 0x0000_8001.
- Assert rst in the READ cycle of an SB -> no memWrite, no respValid, IDLE next cycle; the following LW returns the unmodified word.
